// File: rtl/tick_pkg.sv
// Shared mode encodings and helpers for the tick scheduler.
package tick_pkg;

  typedef enum logic [1:0] {
    MODE_STOP     = 2'b00,
    MODE_PERIODIC = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_RSVD     = 2'b11
  } mode_e;

  // True for the modes that arm a channel; the reserved code behaves as stop.
  function automatic logic mode_arms(input logic [1:0] mode);
    return (mode == MODE_PERIODIC) || (mode == MODE_ONESHOT);
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin search: first set request at or after start.
module rr_arb #(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] gnt_idx_c,
  output logic         gnt_valid_c
);

  // Walk the ring from start; N is a power of two so the index wraps naturally.
  always_comb begin
    gnt_idx_c   = '0;
    gnt_valid_c = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!gnt_valid_c && req[start + W'(i)]) begin
        gnt_valid_c = 1'b1;
        gnt_idx_c   = start + W'(i);
      end
    end
  end

endmodule

// File: rtl/tick_sched.sv
// Prescaled multi-channel tick scheduler with a registered round-robin event port.
module tick_sched
  import tick_pkg::*;
#(
  parameter int unsigned PRE_N = 4,
  parameter int unsigned NCH   = 4,
  parameter int unsigned PW    = 16,
  localparam int unsigned CW   = $clog2(NCH)
) (
  input  logic           clk_in,
  input  logic           rstn,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [PW-1:0]  cfg_period,
  input  logic [1:0]     cfg_mode,
  output logic           evt_valid,
  output logic [CW-1:0]  evt_ch,
  input  logic           evt_ready,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] overrun
);

  logic [PRE_N-1:0] pre_q, pre_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             evt_valid_q, evt_valid_d;
  logic [CW-1:0]    evt_ch_q, evt_ch_d;
  logic [CW-1:0]    ptr_q, ptr_d;
  logic [NCH-1:0]   pend_vec;
  logic [NCH-1:0]   acc_mask;
  logic [NCH-1:0]   arb_req;
  logic [CW-1:0]    gnt_idx;
  logic             gnt_valid;
  logic             base_tick;
  logic             accept;
  logic             cfg_fire;
  logic             cfg_arm;

  assign base_tick = &pre_q;
  assign accept    = evt_valid_q && evt_ready;
  assign cfg_fire  = cfg_valid && cfg_ready_q;
  assign cfg_arm   = mode_arms(cfg_mode) && (cfg_period != '0);
  assign acc_mask  = accept ? (NCH'(1) << evt_ch_q) : '0;
  // The accepted channel is excluded so the next grant moves on immediately.
  assign arb_req   = pend_vec & ~acc_mask;

  // Per-channel countdown, reload and pending/overrun tracking.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic          busy_q, busy_d;
    logic          os_q, os_d;
    logic          pend_q, pend_d;
    logic          ovr_q, ovr_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] per_q, per_d;
    logic          fire;
    logic          cfg_hit;
    logic          acc_hit;

    assign cfg_hit = cfg_fire && (cfg_ch == CW'(g));
    assign acc_hit = accept && (evt_ch_q == CW'(g));

    // Configuration wins over a coincident tick; a fire during accept keeps pending without overrun.
    always_comb begin
      busy_d = busy_q;
      os_d   = os_q;
      pend_d = pend_q;
      ovr_d  = ovr_q;
      cnt_d  = cnt_q;
      per_d  = per_q;
      fire   = 1'b0;
      if (cfg_hit) begin
        if (cfg_arm) begin
          busy_d = 1'b1;
          os_d   = (cfg_mode == MODE_ONESHOT);
          cnt_d  = cfg_period - PW'(1);
          per_d  = cfg_period;
          ovr_d  = 1'b0;
        end else begin
          busy_d = 1'b0;
        end
      end else if (base_tick && busy_q) begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - PW'(1);
        end else begin
          fire = 1'b1;
          if (os_q) busy_d = 1'b0;
          else      cnt_d  = per_q - PW'(1);
        end
      end
      if (acc_hit) pend_d = 1'b0;
      if (fire) begin
        if (pend_q && !acc_hit) ovr_d = 1'b1;
        pend_d = 1'b1;
      end
    end

    // Channel state registers.
    always_ff @(posedge clk_in or negedge rstn) begin
      if (!rstn) begin
        busy_q <= 1'b0;
        os_q   <= 1'b0;
        pend_q <= 1'b0;
        ovr_q  <= 1'b0;
        cnt_q  <= '0;
        per_q  <= '0;
      end else begin
        busy_q <= busy_d;
        os_q   <= os_d;
        pend_q <= pend_d;
        ovr_q  <= ovr_d;
        cnt_q  <= cnt_d;
        per_q  <= per_d;
      end
    end

    assign busy[g]     = busy_q;
    assign overrun[g]  = ovr_q;
    assign pend_vec[g] = pend_q;
  end

  rr_arb #(.N(NCH), .W(CW)) u_arb (
    .req         (arb_req),
    .start       (ptr_q),
    .gnt_idx_c   (gnt_idx),
    .gnt_valid_c (gnt_valid)
  );

  // Prescaler, ready and event-port next state; a new grant loads when the port is free or just accepted.
  always_comb begin
    pre_d       = pre_q + PRE_N'(1);
    cfg_ready_d = 1'b1;
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    ptr_d       = ptr_q;
    if (!evt_valid_q || accept) begin
      evt_valid_d = gnt_valid;
      if (gnt_valid) begin
        evt_ch_d = gnt_idx;
        ptr_d    = gnt_idx + CW'(1);
      end
    end
  end

  // Shared state registers.
  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      pre_q       <= '0;
      cfg_ready_q <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      pre_q       <= pre_d;
      cfg_ready_q <= cfg_ready_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;

endmodule

// File: tb/tb_tick_sched.sv
// Directed and random checks of tick_sched against a tick-count reference model.
module tb_tick_sched;

  localparam int unsigned PRE_N = 2;
  localparam int unsigned NCH   = 4;
  localparam int unsigned PW    = 16;

  logic        clk_in = 1'b0;
  logic        rstn;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_period;
  logic [1:0]  cfg_mode;
  logic        evt_valid;
  logic [1:0]  evt_ch;
  logic        evt_ready;
  logic [3:0]  busy;
  logic [3:0]  overrun;

  always #5 clk_in = ~clk_in;

  tick_sched #(.PRE_N(PRE_N), .NCH(NCH), .PW(PW)) dut (
    .clk_in     (clk_in),
    .rstn       (rstn),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_mode   (cfg_mode),
    .evt_valid  (evt_valid),
    .evt_ch     (evt_ch),
    .evt_ready  (evt_ready),
    .busy       (busy),
    .overrun    (overrun)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: fires are derived from the count of base ticks since arming.
  int         m_edges, m_ticks, m_ptr;
  logic       m_ready, m_valid;
  logic [1:0] m_ch;
  logic [3:0] m_busy, m_os, m_pend, m_ovr;
  int         m_per [4];
  int         m_arm [4];
  int         ev_cnt [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_edges = 0; m_ticks = 0; m_ptr = 0;
    m_ready = 1'b0; m_valid = 1'b0; m_ch = 2'd0;
    m_busy = 4'b0; m_os = 4'b0; m_pend = 4'b0; m_ovr = 4'b0;
    for (int c = 0; c < 4; c++) begin
      m_per[c] = 0;
      m_arm[c] = 0;
    end
  endtask

  task automatic clear_ev();
    for (int c = 0; c < 4; c++) ev_cnt[c] = 0;
  endtask

  // One clock: advance the model with the current inputs, then compare after the edge.
  task automatic step();
    logic       tick, acc, found;
    logic [3:0] accm, fire, req;
    int         k, idx;
    tick  = (m_edges % 4) == 3;
    acc   = m_valid && evt_ready;
    accm  = acc ? (4'b0001 << m_ch) : 4'b0000;
    fire  = 4'b0000;
    if (evt_valid && evt_ready) ev_cnt[evt_ch]++;
    for (int c = 0; c < 4; c++) begin
      if (cfg_valid && m_ready && int'(cfg_ch) == c) begin
        if ((cfg_mode == 2'b01 || cfg_mode == 2'b10) && cfg_period != 16'd0) begin
          m_busy[c] = 1'b1;
          m_os[c]   = (cfg_mode == 2'b10);
          m_per[c]  = int'(cfg_period);
          m_arm[c]  = m_ticks + (tick ? 1 : 0);
          m_ovr[c]  = 1'b0;
        end else begin
          m_busy[c] = 1'b0;
        end
      end else if (tick && m_busy[c]) begin
        k = m_ticks + 1 - m_arm[c];
        if (m_os[c]) begin
          if (k == m_per[c]) begin
            fire[c]   = 1'b1;
            m_busy[c] = 1'b0;
          end
        end else if (k % m_per[c] == 0) begin
          fire[c] = 1'b1;
        end
      end
    end
    req   = m_pend & ~accm;
    m_ovr = m_ovr | (fire & req);
    if (!m_valid || acc) begin
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
        idx = (m_ptr + i) % 4;
        if (!found && req[idx]) begin
          found = 1'b1;
          m_ch  = 2'(idx);
          m_ptr = (idx + 1) % 4;
        end
      end
      m_valid = found;
    end
    m_pend = req | fire;
    if (tick) m_ticks++;
    m_edges++;
    m_ready = 1'b1;
    @(posedge clk_in);
    #1;
    chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
    chk("evt_valid", 32'(evt_valid), 32'(m_valid));
    if (m_valid) chk("evt_ch", 32'(evt_ch), 32'(m_ch));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cfg(input int ch, input int p, input int mode);
    cfg_valid  = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_period = 16'(p);
    cfg_mode   = 2'(mode);
    step();
    cfg_valid  = 1'b0;
  endtask

  // Step until the current cycle's prescaler phase equals r.
  task automatic align(input int r);
    for (int i = 0; i < 4; i++) if ((m_edges % 4) != r) step();
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    cfg_valid = 1'b0;
    evt_ready = 1'b0;
    #1;
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_evt_ch", 32'(evt_ch), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    model_reset();
    @(posedge clk_in);
    #1;
    rstn = 1'b1;
    step();
  endtask

  int first;

  initial begin
    rstn       = 1'b1;
    cfg_valid  = 1'b0;
    cfg_ch     = 2'd0;
    cfg_period = 16'd0;
    cfg_mode   = 2'd0;
    evt_ready  = 1'b0;
    clear_ev();
    model_reset();
    #2;
    do_reset();

    // Periodic ch0, P=3: first event 9-12 cycles after acceptance, then every 12.
    evt_ready = 1'b1;
    cfg(0, 3, 1);
    clear_ev();
    first = -1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (evt_valid && first < 0) first = i;
    end
    chk("periodic_first_in_window", 32'(first >= 9 && first <= 12), 32'd1);
    chk("periodic_event_count", 32'(ev_cnt[0]), 32'd5);

    // One-shot ch2, P=2: exactly one event.
    do_reset();
    evt_ready = 1'b1;
    clear_ev();
    cfg(2, 2, 2);
    idle(100);
    chk("oneshot_event_count", 32'(ev_cnt[2]), 32'd1);
    chk("oneshot_busy2", 32'(busy[2]), 32'd0);

    // All channels periodic P=1 with the consumer stalled, then drained round-robin.
    do_reset();
    cfg(0, 1, 1);
    cfg(1, 1, 1);
    cfg(2, 1, 1);
    cfg(3, 1, 1);
    idle(16);
    chk("overrun_all", 32'(overrun), 32'hF);
    align(0);
    chk("rr_hold_ch0", 32'(evt_ch), 32'd0);
    evt_ready = 1'b1;
    step(); chk("rr_grant_ch1", 32'(evt_ch), 32'd1);
    step(); chk("rr_grant_ch2", 32'(evt_ch), 32'd2);
    step(); chk("rr_grant_ch3", 32'(evt_ch), 32'd3);
    step(); chk("rr_gap_after_tick", 32'(evt_valid), 32'd0);
    chk("accept_fire_no_overrun_change", 32'(overrun), 32'hF);
    step(); chk("rr_restart_ch0", 32'(evt_ch), 32'd0);
    step(); chk("rr_next_ch1", 32'(evt_ch), 32'd1);
    idle(12);

    // Stop a channel that already has an event pending.
    do_reset();
    cfg(1, 1, 1);
    idle(8);
    cfg(1, 1, 0);
    chk("stop_busy1", 32'(busy[1]), 32'd0);
    clear_ev();
    evt_ready = 1'b1;
    idle(40);
    chk("stop_pending_delivered", 32'(ev_cnt[1]), 32'd1);

    // Reconfigure ch3 on a base-tick cycle: the reload takes precedence.
    do_reset();
    evt_ready = 1'b1;
    cfg(3, 2, 1);
    idle(5);
    align(3);
    cfg(3, 2, 1);
    idle(30);

    // Random traffic with a reset dropped in mid-run.
    for (int i = 0; i < 1400; i++) begin
      if (i == 700) begin
        do_reset();
        clear_ev();
        evt_ready = 1'b1;
        idle(30);
        chk("post_reset_no_events", 32'(ev_cnt[0] + ev_cnt[1] + ev_cnt[2] + ev_cnt[3]), 32'd0);
      end
      cfg_valid  = ($urandom_range(0, 9) < 3);
      cfg_ch     = 2'($urandom_range(0, 3));
      cfg_period = 16'($urandom_range(0, 5));
      cfg_mode   = 2'($urandom_range(0, 3));
      evt_ready  = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tick_sched.md
TICK_SCHED -- requirements
Module: tick_sched

Interface
REQ-001 SHALL have parameter PRE_N, default 4: base prescaler width; one base tick every 2^PRE_N clk_in cycles.
REQ-002 SHALL have parameter NCH, default 4: number of timer channels, a power of two, 2..8.
REQ-003 SHALL have parameter PW, default 16: channel period width.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk_in  input  1  system clock; all state on rising edge.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 cfg_valid  input  1  configuration request.
REQ-008 cfg_ready  output  1  configuration can be accepted.
REQ-009 cfg_ch  input  clog2(NCH)  target channel.
REQ-010 cfg_period  input  PW  period P in base ticks.
REQ-011 cfg_mode  input  2  00 stop, 01 periodic, 10 one-shot, 11 treated as stop.
REQ-012 evt_valid  output  1  event available.
REQ-013 evt_ch  output  clog2(NCH)  channel of the presented event.
REQ-014 evt_ready  input  1  consumer accepts the event.
REQ-015 busy  output  NCH  channel armed.
REQ-016 overrun  output  NCH  sticky: event lost because the previous one was still pending.

Function
REQ-017 SHALL run a free-running PRE_N-bit counter; base_tick is high for the single cycle when the counter is all ones.
REQ-018 SHALL accept a configuration on a cycle with cfg_valid && cfg_ready; cfg_ready SHALL be 1 on every cycle after the first edge following reset release.
REQ-019 On acceptance with mode 01 or 10 and P != 0: busy[ch] <= 1, cnt[ch] <= P-1, overrun[ch] <= 0; pending[ch] is unchanged.
REQ-020 On acceptance with mode 00, mode 11, or P == 0: busy[ch] <= 0; pending[ch] and overrun[ch] are unchanged.
REQ-021 Configuration acceptance SHALL take priority over a base_tick for the same channel in the same cycle; the tick is ignored for that channel.
REQ-022 On base_tick, each busy channel with cnt != 0 SHALL decrement.
REQ-023 On base_tick, each busy channel with cnt == 0 SHALL fire:
- pending set.
- Periodic: cnt <= P-1.
- One-shot: busy cleared.
REQ-024 Firing while pending is already set SHALL set overrun and leave pending at 1; events do not accumulate.
REQ-025 Periodic channel with period P SHALL fire every P*2^PRE_N cycles; the first fire SHALL occur on the P-th base_tick after acceptance.
REQ-026 The event port SHALL be a registered round-robin arbiter over pending. evt_valid SHALL rise the cycle after pending is set.
REQ-027 The search SHALL start at the channel after the last granted one; the initial start after reset is channel 0.
REQ-028 evt_valid and evt_ch SHALL hold stable until evt_valid && evt_ready.
REQ-029 On accept, pending[evt_ch] SHALL clear. If that channel fires in the same cycle, pending SHALL stay 1 and overrun SHALL not set.
REQ-030 After an accept, the next grant SHALL be presented the following cycle, sustaining one event per cycle.
REQ-031 A channel stopped by configuration SHALL still deliver an already-pending event.

Reset
REQ-032 While rstn is low, the following SHALL be 0: prescaler counter, cnt, busy, pending, overrun, evt_valid, evt_ch, cfg_ready, and the round-robin pointer.
REQ-033 Reset asserted mid-operation SHALL discard pending events immediately, without completing handshakes.

Structure
REQ-034 Mode encodings (STOP, PERIODIC, ONESHOT) SHALL be constants in a shared package, tick_pkg.
REQ-035 The round-robin arbiter SHALL be one sub-module, rr_arb: NCH request bits in; grant index and grant-valid out.
REQ-036 The channel logic SHALL be generated per channel in the top module; no per-channel sub-module.

Verification (PRE_N=2, NCH=4, PW=16)
REQ-037 Periodic timing: ch0 periodic, P=3, evt_ready=1 -> evt_valid with evt_ch=0 every 12 cycles; first event 9-12 cycles after acceptance.
REQ-038 One-shot: ch2 one-shot, P=2 -> exactly one event on ch2; busy[2] falls on the firing tick; no further events over 100 cycles.
REQ-039 Arbitration and overrun: all 4 channels periodic, P=1, evt_ready=0 for 3 base ticks.
- overrun=4'b1111.
- After evt_ready=1, grants ch0, ch1, ch2, ch3 on consecutive cycles.
- Next tick's grants continue round-robin from ch0.
REQ-040 Stop with pending: ch1 periodic, P=1; event pending; stop ch1 (mode 00) -> pending ch1 event still delivered; busy[1]=0; no new events.
REQ-041 Reset mid-run: rstn low mid-run for 1 cycle -> all outputs 0 immediately; no events until reconfigured.
REQ-042 Same-cycle collisions:
- cfg on the same cycle as base_tick for ch3 -> reload wins.
- Accept and fire on the same cycle -> pending stays 1; overrun stays 0.
